// File: rtl/ldm_result_reader_pkg.sv
// Shared constants and FSM encoding for the LDM result reader.
package ldm_result_reader_pkg;

  localparam int unsigned DATA_BITS      = 64;
  localparam int unsigned LDM_WORD_BYTES = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } ldm_rd_state_e;

endpackage

// File: rtl/ldm_rd_fifo.sv
// Small first-word-fall-through FIFO holding LDM words plus their last flag.
// Pointer wrap relies on Depth being a power of two.
module ldm_rd_fifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;

  // Storage and pointers; a push into a full FIFO is legal when the head pops on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ldm_result_reader.sv
// Walks a window of LDM after the core completes and streams the 64-bit words out
// with valid/ready/last. The read address is registered, so the LDM word for the
// address on the port is captured at the following edge.
module ldm_result_reader
  import ldm_result_reader_pkg::*;
#(
  parameter int unsigned CNT_BITS   = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] base_addr_in_64,
  input  logic [CNT_BITS-1:0]  word_cnt_in,
  input  logic                 complete_in,
  output logic [DATA_BITS-1:0] LDM_addra_out_64,
  output logic [7:0]           LDM_wea_out,
  input  logic [DATA_BITS-1:0] LDM_douta_in_64,
  output logic [DATA_BITS-1:0] dout_64,
  output logic                 dout_valid,
  output logic                 dout_last,
  input  logic                 dout_ready,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OccW     = FifoCntW + 1;

  ldm_rd_state_e        state_q;
  logic                 cmp_q;
  logic                 armed_q;
  logic [DATA_BITS-1:0] addr_q;
  logic [CNT_BITS-1:0]  rem_q;
  logic                 inflight_q;
  logic                 inflight_last_q;
  logic                 busy_q;
  logic                 done_q;

  logic [DATA_BITS:0]   fifo_rdata;
  logic [FifoCntW-1:0]  fifo_count;
  logic                 pop;
  logic                 trig;
  logic                 issue_ok;
  logic                 empty_next;
  logic [OccW-1:0]      occ;

  assign dout_valid = (fifo_count != '0);
  assign pop        = dout_valid & dout_ready;
  // armed_q keeps the first post-reset cycle sample-only.
  assign trig       = armed_q & complete_in & ~cmp_q & (state_q == StIdle);
  // Occupancy counts the word landing this edge; a same-edge pop frees a slot.
  assign occ        = {1'b0, fifo_count} + OccW'(inflight_q);
  assign issue_ok   = occ < (OccW'(FIFO_DEPTH) + OccW'(pop));
  assign empty_next = ~inflight_q & ((fifo_count == '0) ||
                                     ((fifo_count == FifoCntW'(1)) & pop));

  // Control FSM with address/issue bookkeeping and registered status outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q         <= StIdle;
      cmp_q           <= 1'b0;
      armed_q         <= 1'b0;
      addr_q          <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      cmp_q      <= complete_in;
      armed_q    <= 1'b1;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trig) begin
            busy_q <= 1'b1;
            if (word_cnt_in == '0) begin
              // An empty window idles one cycle in drain so done lands like any readout.
              state_q <= StDrain;
            end else begin
              addr_q          <= base_addr_in_64 & ~DATA_BITS'(LDM_WORD_BYTES - 1);
              inflight_q      <= 1'b1;
              inflight_last_q <= (word_cnt_in == CNT_BITS'(1));
              rem_q           <= word_cnt_in - CNT_BITS'(1);
              state_q         <= StRead;
            end
          end
        end
        StRead: begin
          if (rem_q == '0) begin
            state_q <= StDrain;
          end else if (issue_ok) begin
            addr_q          <= addr_q + DATA_BITS'(LDM_WORD_BYTES);
            inflight_q      <= 1'b1;
            inflight_last_q <= (rem_q == CNT_BITS'(1));
            rem_q           <= rem_q - CNT_BITS'(1);
            if (rem_q == CNT_BITS'(1)) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (empty_next) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  ldm_rd_fifo #(
    .Width (DATA_BITS + 1),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (inflight_q),
    .wdata_i ({inflight_last_q, LDM_douta_in_64}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign LDM_addra_out_64 = addr_q;
  assign LDM_wea_out      = 8'h00;
  assign dout_64          = fifo_rdata[DATA_BITS-1:0];
  assign dout_last        = dout_valid & fifo_rdata[DATA_BITS];
  assign busy_out         = busy_q;
  assign done_out         = done_q;

endmodule

// File: tb/tb_ldm_result_reader.sv
// Directed bench for ldm_result_reader with a combinational LDM model.
module tb_ldm_result_reader;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] base_addr_in_64;
  logic [15:0] word_cnt_in;
  logic        complete_in;
  logic [63:0] LDM_addra_out_64;
  logic [7:0]  LDM_wea_out;
  logic [63:0] LDM_douta_in_64;
  logic [63:0] dout_64;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready;
  logic        busy_out;
  logic        done_out;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  ldm_result_reader #(
    .CNT_BITS   (16),
    .FIFO_DEPTH (2)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .base_addr_in_64  (base_addr_in_64),
    .word_cnt_in      (word_cnt_in),
    .complete_in      (complete_in),
    .LDM_addra_out_64 (LDM_addra_out_64),
    .LDM_wea_out      (LDM_wea_out),
    .LDM_douta_in_64  (LDM_douta_in_64),
    .dout_64          (dout_64),
    .dout_valid       (dout_valid),
    .dout_last        (dout_last),
    .dout_ready       (dout_ready),
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    case (a)
      64'h10:  return 64'h1;
      64'h18:  return 64'h8082;
      64'h20:  return 64'h8000_0000_0000_808A;
      default: return {~a[31:0], a[31:0]};
    endcase
  endfunction

  assign LDM_douta_in_64 = mem_word(LDM_addra_out_64);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic trigger(input logic [63:0] base, input logic [15:0] cnt);
    base_addr_in_64 = base;
    word_cnt_in     = cnt;
    complete_in     = 1'b1;
    tick();
    complete_in     = 1'b0;
  endtask

  // Drives ready from a pattern, verifies every accepted word against the LDM model.
  task automatic collect(input string name, input logic [63:0] base, input int cnt,
                         input logic [15:0] pat, input int plen, input bit retrig,
                         output int got, output int done_cnt, output int done_cyc,
                         output int first_hs, output int last_hs);
    logic [63:0] abase;
    logic [63:0] exp_d;
    logic [63:0] prev_data;
    logic        prev_last;
    logic        prev_stall;
    abase      = base & ~64'h7;
    got        = 0;
    done_cnt   = 0;
    done_cyc   = -1;
    first_hs   = -1;
    last_hs    = -1;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    for (int c = 0; c < cnt * 4 + 10; c++) begin
      dout_ready = pat[c % plen];
      if (retrig) begin
        if (c == 2) begin
          complete_in     = 1'b1;
          base_addr_in_64 = 64'h200;
          word_cnt_in     = 16'd7;
        end else if (c == 3) begin
          complete_in = 1'b0;
        end
      end
      tests_run++;
      if (LDM_wea_out !== 8'h00) begin
        tests_failed++;
        $display("FAIL %s wea c%0d: got %h, expected 00", name, c, LDM_wea_out);
      end
      if (prev_stall) begin
        tests_run++;
        if (dout_valid !== 1'b1 || dout_64 !== prev_data || dout_last !== prev_last) begin
          tests_failed++;
          $display("FAIL %s stall_hold c%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                   name, c, dout_valid, dout_64, dout_last, prev_data, prev_last);
        end
      end
      if (dout_valid === 1'b1 && dout_ready) begin
        tests_run++;
        if (got >= cnt) begin
          tests_failed++;
          $display("FAIL %s extra_word c%0d: got word %0d, expected only %0d", name, c,
                   got + 1, cnt);
        end else begin
          exp_d = mem_word(abase + 64'(8 * got));
          if (dout_64 !== exp_d || dout_last !== (got == cnt - 1)) begin
            tests_failed++;
            $display("FAIL %s word%0d: got d=%h l=%b, expected d=%h l=%b", name, got,
                     dout_64, dout_last, exp_d, (got == cnt - 1));
          end
        end
        if (first_hs < 0) first_hs = c;
        last_hs = c;
        got++;
      end
      if (done_out === 1'b1) begin
        done_cnt++;
        done_cyc = c;
      end
      prev_stall = (dout_valid === 1'b1) && !dout_ready;
      prev_data  = dout_64;
      prev_last  = dout_last;
      tick();
    end
    tests_run++;
    if (got != cnt || done_cnt != 1 || busy_out !== 1'b0 || dout_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s totals: got words=%0d dones=%0d busy=%b valid=%b, expected %0d 1 0 0",
               name, got, done_cnt, busy_out, dout_valid, cnt);
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (LDM_addra_out_64 !== 64'h0 || LDM_wea_out !== 8'h0 || dout_64 !== 64'h0 ||
        dout_valid !== 1'b0 || dout_last !== 1'b0 || busy_out !== 1'b0 ||
        done_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: got a=%h we=%h d=%h v=%b l=%b b=%b dn=%b, expected zeros",
               LDM_addra_out_64, LDM_wea_out, dout_64, dout_valid, dout_last, busy_out,
               done_out);
    end
    tick();
    RST = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_basic();
    int got, dn, dc, fh, lh;
    trigger(64'h10, 16'd3);
    tests_run++;
    if (busy_out !== 1'b1 || LDM_addra_out_64 !== 64'h10 || dout_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_trigger: got busy=%b addr=%h valid=%b, expected 1 10 0",
               busy_out, LDM_addra_out_64, dout_valid);
    end
    collect("basic", 64'h10, 3, 16'hFFFF, 1, 1'b0, got, dn, dc, fh, lh);
    tests_run++;
    if (fh != 1 || lh != 3 || dc != 4) begin
      tests_failed++;
      $display("FAIL basic_timing: got first=%0d last=%0d done=%0d, expected 1 3 4",
               fh, lh, dc);
    end
  endtask

  task automatic test_backpressure();
    int got, dn, dc, fh, lh;
    trigger(64'h10, 16'd3);
    // ready sequence 1,0,0,1,0,1 (bit 0 first)
    collect("stall", 64'h10, 3, 16'b101001, 6, 1'b0, got, dn, dc, fh, lh);
  endtask

  task automatic test_zero_count();
    trigger(64'h40, 16'd0);
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (dout_valid !== 1'b0 || LDM_addra_out_64 !== 64'h20 ||
          done_out !== (c == 1) || busy_out !== (c == 0)) begin
        tests_failed++;
        $display("FAIL zero_cnt c%0d: got v=%b a=%h dn=%b b=%b, expected 0 20 %b %b", c,
                 dout_valid, LDM_addra_out_64, done_out, busy_out, (c == 1), (c == 0));
      end
      tick();
    end
  endtask

  task automatic test_align_wrap();
    int got, dn, dc, fh, lh;
    trigger(64'h13, 16'd2);
    tests_run++;
    if (LDM_addra_out_64 !== 64'h10) begin
      tests_failed++;
      $display("FAIL align_addr: got %h, expected 10", LDM_addra_out_64);
    end
    collect("align", 64'h13, 2, 16'hFFFF, 1, 1'b0, got, dn, dc, fh, lh);
    trigger(64'hFFFF_FFFF_FFFF_FFF8, 16'd2);
    tests_run++;
    if (LDM_addra_out_64 !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      tests_failed++;
      $display("FAIL wrap_addr0: got %h, expected fffffffffffffff8", LDM_addra_out_64);
    end
    tick();
    tests_run++;
    if (LDM_addra_out_64 !== 64'h0 || dout_64 !== 64'h0000_0007_FFFF_FFF8) begin
      tests_failed++;
      $display("FAIL wrap_addr1: got a=%h d=%h, expected 0 00000007fffffff8",
               LDM_addra_out_64, dout_64);
    end
    collect("wrap", 64'hFFFF_FFFF_FFFF_FFF8, 2, 16'hFFFF, 1, 1'b0, got, dn, dc, fh, lh);
  endtask

  task automatic test_reset_mid();
    int got, dn, dc, fh, lh;
    dout_ready = 1'b1;
    trigger(64'h100, 16'd5);
    tick();
    tick();
    tick();
    tests_run++;
    if (dout_valid !== 1'b1 || busy_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_pre: got v=%b b=%b, expected 1 1", dout_valid, busy_out);
    end
    RST = 1'b0;
    #1;
    tests_run++;
    if (LDM_addra_out_64 !== 64'h0 || dout_64 !== 64'h0 || dout_valid !== 1'b0 ||
        dout_last !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got a=%h d=%h v=%b l=%b b=%b dn=%b, expected zeros",
               LDM_addra_out_64, dout_64, dout_valid, dout_last, busy_out, done_out);
    end
    complete_in = 1'b1;
    tick();
    tick();
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (busy_out !== 1'b0 || dout_valid !== 1'b0 || LDM_addra_out_64 !== 64'h0) begin
        tests_failed++;
        $display("FAIL held_complete c%0d: got b=%b v=%b a=%h, expected 0 0 0", c,
                 busy_out, dout_valid, LDM_addra_out_64);
      end
    end
    complete_in = 1'b0;
    tick();
    trigger(64'h100, 16'd5);
    tests_run++;
    if (busy_out !== 1'b1 || LDM_addra_out_64 !== 64'h100) begin
      tests_failed++;
      $display("FAIL restart: got b=%b a=%h, expected 1 100", busy_out, LDM_addra_out_64);
    end
    collect("restart", 64'h100, 5, 16'hFFFF, 1, 1'b0, got, dn, dc, fh, lh);
  endtask

  task automatic test_retrigger();
    int got, dn, dc, fh, lh;
    trigger(64'h10, 16'd3);
    collect("retrig", 64'h10, 3, 16'hFFFF, 1, 1'b1, got, dn, dc, fh, lh);
    tests_run++;
    if (LDM_addra_out_64 !== 64'h20) begin
      tests_failed++;
      $display("FAIL retrig_addr: got %h, expected 20", LDM_addra_out_64);
    end
  endtask

  initial begin
    RST             = 1'b0;
    base_addr_in_64 = '0;
    word_cnt_in     = '0;
    complete_in     = 1'b0;
    dout_ready      = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_align_wrap();
    test_reset_mid();
    test_retrigger();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ldm_result_reader.md
# ldm_result_reader

Read-side companion to the LDM load port of the RISCV core. After the core raises `complete_out`, the block walks a configured window of local data memory (LDM) 64-bit word by word. It returns the words to the host as a valid/ready stream with a last marker. It owns the LDM port A address during readout, keeps write-enable at zero throughout, and hides the one-cycle LDM read latency behind a 2-entry buffer so backpressure never drops or duplicates a word.

## Interface
Parameters:
- `CNT_BITS`, 16, width of the word-count register.
- `FIFO_DEPTH`, 2, output buffer entries. Fixed at 2; any other value is unsupported.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RST`  in  1  reset. Asynchronous assert, active-low: 0 holds the block in reset.
- `base_addr_in_64`  in  `DATA_BITS`  LDM byte address of the first word. Bits [2:0] are ignored and treated as 0.
- `word_cnt_in`  in  `CNT_BITS`  number of 64-bit words to read.
- `complete_in`  in  1  connects to the core's `complete_out`. A rising edge triggers a readout.
- `LDM_addra_out_64`  out  `DATA_BITS`  LDM port A byte address.
- `LDM_wea_out`  out  8  LDM byte write enables. Constant 8'h00.
- `LDM_douta_in_64`  in  `DATA_BITS`  LDM read data, valid one cycle after the address.
- `dout_64`  out  `DATA_BITS`  stream data.
- `dout_valid`  out  1  stream valid.
- `dout_last`  out  1  qualifies the final word of a readout.
- `dout_ready`  in  1  stream ready from the host.
- `busy_out`  out  1  high from the trigger until the last word is accepted.
- `done_out`  out  1  one-cycle pulse after the last handshake.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - `complete_in` is registered once, into `cmp_d`. The trigger condition is `complete_in & ~cmp_d`.
  - On trigger, the block latches the base address (with [2:0] forced to 0) and `word_cnt_in`.
  - If the count is 0, the next state is DONE. Otherwise the next state is READ.
- READ:
  - The block issues one LDM read per cycle when `fifo_count + inflight < 2`. The address then increments by 8 and the remaining-issue counter decrements.
  - Exactly one read may be in flight. The returned word is written into the FIFO on the following edge.
  - When the last read has been issued, the next state is DRAIN.
- DRAIN: wait until the in-flight read has landed and the FIFO is empty, then go to DONE.
- DONE: `done_out` is high for one cycle, then the FSM returns to IDLE.
- `dout_last` is 1 for the word whose output index equals count−1, tracked by a delivered-word counter.
- Address arithmetic is modulo 2^`DATA_BITS`. A window that crosses the top of memory wraps to 0 without raising an error.
- A trigger edge while not in IDLE is ignored. `cmp_d` still tracks `complete_in`.
- `base_addr_in_64` and `word_cnt_in` are sampled only at the trigger. Later changes have no effect on a readout in progress.

## Timing
- Reset values:
  - `LDM_addra_out_64` = 0, `LDM_wea_out` = 0, `dout_64` = 0.
  - `dout_valid`, `dout_last`, `busy_out`, `done_out` = 0.
  - FSM = IDLE, FIFO empty, `cmp_d` = 0.
- Trigger sampled at edge k:
  - `busy_out` = 1 and `LDM_addra_out_64` = base, both after edge k.
  - Data is captured at edge k+1.
  - `dout_valid` = 1 after edge k+1.
- With `dout_ready` held at 1, throughput is 1 word per cycle. N words finish with the last handshake at edge k+N+1. `done_out` is high in the following cycle and `busy_out` drops with it.
- A handshake occurs when `dout_valid & dout_ready` at an edge. `dout_64` and `dout_last` are held stable while valid is high and ready is low.
- If the FIFO is full and an in-flight read lands in the same cycle as a pop, the push is accepted. The issue rule above guarantees no overflow.
- Reset asserted mid-readout: all state clears asynchronously and the partial stream is abandoned. A new readout requires a fresh rising edge of `complete_in` after `RST` deasserts. A `complete_in` already high at release does not trigger, because `cmp_d` resets to 0 only after its first sample. Implement this by treating the first post-reset cycle as sample-only.

## Structure
- Uses `DATA_BITS` from `common.vh`. Add `LDM_WORD_BYTES` (8) and the FSM state encodings to `common.vh`.
- Sub-module `ldm_rd_fifo`:
  - 2-entry, `DATA_BITS`+1 wide (data plus last).
  - Signals: push, pop, count, first-word fall-through.
- The top level holds the FSM, the address/issue/deliver counters, edge detect and in-flight flag. Target size is 150–250 lines.

## Test plan
- Preload LDM 0x10=0x1, 0x18=0x8082, 0x20=0x800000000000808A. Set base 0x10, cnt 3, pulse `complete_in`, ready=1. Required: the three words are delivered in order on consecutive cycles, last is set on 0x800000000000808A, and `done_out` pulses once.
- Same data and window, with `dout_ready` toggling 1,0,0,1,0,1. Required: no word is lost or duplicated, data is stable while stalled, and `LDM_wea_out` reads 0 throughout.
- cnt=0 trigger. Required: `done_out` pulses 2 cycles after the trigger, with no `dout_valid` and no address change.
- Base 0x13, cnt 2. Required: reads from 0x10 and 0x18. Also base 2^`DATA_BITS`−8, cnt 2. Required: second address wraps to 0.
- Assert `RST` low after the 2nd of 5 words. Required: all outputs return to their reset values immediately. A trigger with `complete_in` already high at release is ignored; a new rising edge restarts the readout from base.
- A second `complete_in` edge mid-readout. Required: it is ignored, and the stream completes with the original count.
